// File: rtl/wb_interconnect.sv
// Shared-bus Wishbone interconnect: round-robin arbitration among masters with bus
// lock, address decode to one slave, response routing, decode-miss error and watchdog.
module wb_interconnect #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TAG_WIDTH      = 3,
    parameter int MASTER_COUNT   = 2,
    parameter int SLAVE_COUNT    = 2,
    parameter logic [SLAVE_COUNT*ADDR_WIDTH-1:0] SLAVE_ADDR = '0,
    parameter logic [SLAVE_COUNT*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                  sys_clk,
    input  logic                                  sys_rst_n,
    input  logic [MASTER_COUNT-1:0]               master_cyc,
    input  logic [MASTER_COUNT-1:0]               master_stb,
    input  logic [MASTER_COUNT-1:0]               master_we,
    input  logic [MASTER_COUNT*TAG_WIDTH-1:0]     master_tag,
    input  logic [MASTER_COUNT*DATA_WIDTH/8-1:0]  master_sel,
    input  logic [MASTER_COUNT*ADDR_WIDTH-1:0]    master_adr,
    input  logic [MASTER_COUNT*DATA_WIDTH-1:0]    master_mosi,
    output logic [MASTER_COUNT*DATA_WIDTH-1:0]    master_miso,
    output logic [MASTER_COUNT-1:0]               master_ack,
    output logic [MASTER_COUNT-1:0]               master_err,
    output logic [SLAVE_COUNT-1:0]                slave_cyc,
    output logic [SLAVE_COUNT-1:0]                slave_stb,
    output logic [SLAVE_COUNT-1:0]                slave_we,
    output logic [SLAVE_COUNT*TAG_WIDTH-1:0]      slave_tag,
    output logic [SLAVE_COUNT*DATA_WIDTH/8-1:0]   slave_sel,
    output logic [SLAVE_COUNT*ADDR_WIDTH-1:0]     slave_adr,
    output logic [SLAVE_COUNT*DATA_WIDTH-1:0]     slave_mosi,
    input  logic [SLAVE_COUNT*DATA_WIDTH-1:0]     slave_miso,
    input  logic [SLAVE_COUNT-1:0]                slave_ack,
    input  logic [SLAVE_COUNT-1:0]                slave_err,
    output logic                                  grant_valid,
    output logic [((MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1)-1:0] grant_idx
);

    localparam int MW   = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;
    localparam int SW   = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;
    localparam int BW   = DATA_WIDTH / 8;
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e          state_q, state_d;
    logic [MW-1:0]   grant_q, grant_d;   // owner in BUSY, last owner in IDLE
    logic            miss_err_q, miss_err_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic                  busy;
    logic                  g_cyc, g_stb, g_we;
    logic [TAG_WIDTH-1:0]  g_tag;
    logic [BW-1:0]         g_sel;
    logic [ADDR_WIDTH-1:0] g_adr;
    logic [DATA_WIDTH-1:0] g_mosi;
    logic                  hit;
    logic [SW-1:0]         sel_idx;
    logic                  req_stb, s_ack, s_err, stalled, timeout;

    assign busy = (state_q == BUSY);

    // NOTE: every signal gets a default before any conditional write so no latch is inferred.
    always_comb begin
        g_cyc  = 1'b0;
        g_stb  = 1'b0;
        g_we   = 1'b0;
        g_tag  = '0;
        g_sel  = '0;
        g_adr  = '0;
        g_mosi = '0;
        if (busy) begin
            g_cyc  = master_cyc[grant_q];
            g_stb  = master_stb[grant_q];
            g_we   = master_we[grant_q];
            g_tag  = master_tag[int'(grant_q)*TAG_WIDTH +: TAG_WIDTH];
            g_sel  = master_sel[int'(grant_q)*BW +: BW];
            g_adr  = master_adr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
            g_mosi = master_mosi[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Descending scan so the lowest matching slave is the final assignment.
    always_comb begin
        hit     = 1'b0;
        sel_idx = '0;
        for (int i = SLAVE_COUNT - 1; i >= 0; i--) begin
            if ((g_adr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit     = 1'b1;
                sel_idx = SW'(i);
            end
        end
    end

    assign req_stb = g_cyc & g_stb & hit;
    assign s_ack   = slave_ack[sel_idx];
    assign s_err   = slave_err[sel_idx];
    assign stalled = req_stb & ~s_ack & ~s_err;
    assign timeout = (TIMEOUT_CYCLES != 0) && stalled && (wd_q == WD_LIMIT);

    assign wd_d       = (!stalled || timeout) ? '0 : wd_q + WD_W'(1);
    assign miss_err_d = g_cyc & g_stb & ~hit & ~miss_err_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (|master_cyc) begin
                    state_d = BUSY;
                    for (int k = MASTER_COUNT; k >= 1; k--) begin
                        if (master_cyc[(int'(grant_q) + k) % MASTER_COUNT])
                            grant_d = MW'((int'(grant_q) + k) % MASTER_COUNT);
                    end
                end
            end
            BUSY: begin
                if (!master_cyc[grant_q])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            grant_q    <= MW'(MASTER_COUNT - 1);
            miss_err_q <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            miss_err_q <= miss_err_d;
            wd_q       <= wd_d;
        end
    end

    always_comb begin
        slave_cyc  = '0;
        slave_stb  = '0;
        master_ack = '0;
        master_err = '0;
        if (g_cyc && hit && !timeout) begin
            slave_cyc[sel_idx] = 1'b1;
            slave_stb[sel_idx] = g_stb;
        end
        if (busy) begin
            master_ack[grant_q] = req_stb & s_ack & ~s_err;
            master_err[grant_q] = (req_stb & s_err) | miss_err_q | timeout;
        end
    end

    assign slave_we    = {SLAVE_COUNT{g_we}};
    assign slave_tag   = {SLAVE_COUNT{g_tag}};
    assign slave_sel   = {SLAVE_COUNT{g_sel}};
    assign slave_adr   = {SLAVE_COUNT{g_adr}};
    assign slave_mosi  = {SLAVE_COUNT{g_mosi}};
    assign master_miso = {MASTER_COUNT{(g_cyc && hit) ? slave_miso[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}}}};

    assign grant_valid = busy;
    assign grant_idx   = grant_q;

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed bench for wb_interconnect: two masters, two slaves, watchdog limit of four cycles.
module tb_wb_interconnect;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [1:0]  master_cyc, master_stb, master_we;
    logic [5:0]  master_tag;
    logic [7:0]  master_sel;
    logic [63:0] master_adr, master_mosi, master_miso;
    logic [1:0]  master_ack, master_err;
    logic [1:0]  slave_cyc, slave_stb, slave_we;
    logic [5:0]  slave_tag;
    logic [7:0]  slave_sel;
    logic [63:0] slave_adr, slave_mosi, slave_miso;
    logic [1:0]  slave_ack, slave_err;
    logic        grant_valid;
    logic [0:0]  grant_idx;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    wb_interconnect #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(3),
        .MASTER_COUNT(2), .SLAVE_COUNT(2),
        .SLAVE_ADDR(64'h0000_4000_0000_0000),
        .SLAVE_MASK(64'hFFFF_C000_FFFF_C000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .master_cyc(master_cyc), .master_stb(master_stb), .master_we(master_we),
        .master_tag(master_tag), .master_sel(master_sel), .master_adr(master_adr),
        .master_mosi(master_mosi), .master_miso(master_miso),
        .master_ack(master_ack), .master_err(master_err),
        .slave_cyc(slave_cyc), .slave_stb(slave_stb), .slave_we(slave_we),
        .slave_tag(slave_tag), .slave_sel(slave_sel), .slave_adr(slave_adr),
        .slave_mosi(slave_mosi), .slave_miso(slave_miso),
        .slave_ack(slave_ack), .slave_err(slave_err),
        .grant_valid(grant_valid), .grant_idx(grant_idx)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                           input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [2:0] tag);
        master_cyc[m]           = cyc;
        master_stb[m]           = stb;
        master_we[m]            = we;
        master_adr[m*32 +: 32]  = adr;
        master_mosi[m*32 +: 32] = dat;
        master_sel[m*4 +: 4]    = sel;
        master_tag[m*3 +: 3]    = tag;
    endtask

    task automatic clear_all();
        master_cyc = '0; master_stb = '0; master_we = '0; master_tag = '0;
        master_sel = '0; master_adr = '0; master_mosi = '0;
        slave_miso = '0; slave_ack = '0; slave_err = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_grant_valid: got %0b want 0", grant_valid); end
        checks++; if (grant_idx !== 1'b1) begin errors++; $display("FAIL reset_grant_idx: got %0d want 1", grant_idx); end
        checks++; if (slave_cyc !== 2'b00 || slave_stb !== 2'b00) begin errors++; $display("FAIL reset_slave_strobes: cyc %b stb %b want 00", slave_cyc, slave_stb); end
        checks++; if (master_ack !== 2'b00 || master_err !== 2'b00) begin errors++; $display("FAIL reset_master_resp: ack %b err %b want 00", master_ack, master_err); end
        sys_rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        drive_m(0, 1, 1, 0, 32'h0000_4010, 32'h0, 4'hF, 3'd0);
        #1;
        checks++; if (slave_stb !== 2'b00) begin errors++; $display("FAIL a_pre_grant_stb: got %b want 00", slave_stb); end
        step();
        checks++; if (grant_valid !== 1'b1 || grant_idx !== 1'b0) begin errors++; $display("FAIL a_grant: valid %0b idx %0d want 1/0", grant_valid, grant_idx); end
        checks++; if (slave_stb !== 2'b10 || slave_cyc !== 2'b10) begin errors++; $display("FAIL a_slave_stb: stb %b cyc %b want 10/10", slave_stb, slave_cyc); end
        checks++; if (slave_adr !== {2{32'h0000_4010}}) begin errors++; $display("FAIL a_slave_adr: got %h want %h", slave_adr, {2{32'h0000_4010}}); end
        slave_miso = {32'hCAFE_F00D, 32'h0};
        slave_ack  = 2'b10;
        #1;
        checks++; if (master_ack !== 2'b01) begin errors++; $display("FAIL a_master_ack: got %b want 01", master_ack); end
        checks++; if (master_miso !== {2{32'hCAFE_F00D}}) begin errors++; $display("FAIL a_master_miso: got %h want %h", master_miso, {2{32'hCAFE_F00D}}); end
        step();
        clear_all();
        #1;
        checks++; if (master_ack !== 2'b00) begin errors++; $display("FAIL a_ack_once: got %b want 00", master_ack); end
        step();
        checks++; if (grant_valid !== 1'b0 || grant_idx !== 1'b0) begin errors++; $display("FAIL a_release: valid %0b idx %0d want 0/0", grant_valid, grant_idx); end
    endtask

    task automatic test_decode_miss();
        drive_m(1, 1, 1, 0, 32'h0000_9000, 32'h0, 4'hF, 3'd1);
        step();
        checks++; if (grant_valid !== 1'b1 || grant_idx !== 1'b1) begin errors++; $display("FAIL c_grant: valid %0b idx %0d want 1/1", grant_valid, grant_idx); end
        checks++; if (slave_stb !== 2'b00 || slave_cyc !== 2'b00) begin errors++; $display("FAIL c_no_strobe: stb %b cyc %b want 00/00", slave_stb, slave_cyc); end
        checks++; if (master_err !== 2'b00) begin errors++; $display("FAIL c_err_early: got %b want 00", master_err); end
        step();
        checks++; if (master_err !== 2'b10) begin errors++; $display("FAIL c_err_pulse: got %b want 10", master_err); end
        checks++; if (slave_stb !== 2'b00) begin errors++; $display("FAIL c_no_strobe2: got %b want 00", slave_stb); end
        clear_all();
        step();
        checks++; if (master_err !== 2'b00) begin errors++; $display("FAIL c_err_once: got %b want 00", master_err); end
    endtask

    task automatic test_back_to_back();
        logic [0:0] exp_idx [4];
        logic [1:0] exp_stb [4];
        exp_idx = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_stb = '{2'b01, 2'b10, 2'b01, 2'b10};
        drive_m(0, 1, 1, 1, 32'h0000_0100, 32'h1111_0000, 4'hF, 3'd2);
        drive_m(1, 1, 1, 0, 32'h0000_4020, 32'h0, 4'hF, 3'd3);
        for (int n = 0; n < 4; n++) begin
            step();
            checks++; if (grant_valid !== 1'b1 || grant_idx !== exp_idx[n]) begin errors++; $display("FAIL b_grant_%0d: valid %0b idx %0d want 1/%0d", n, grant_valid, grant_idx, exp_idx[n]); end
            checks++; if (slave_stb !== exp_stb[n]) begin errors++; $display("FAIL b_slave_stb_%0d: got %b want %b", n, slave_stb, exp_stb[n]); end
            slave_ack = exp_stb[n];
            #1;
            checks++; if (master_ack !== (2'b01 << exp_idx[n])) begin errors++; $display("FAIL b_ack_%0d: got %b want %b", n, master_ack, 2'b01 << exp_idx[n]); end
            step();
            slave_ack = 2'b00;
            drive_m(int'(exp_idx[n]), 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'd0);
            step();
            if (n < 3) begin
                if (exp_idx[n] == 1'b0) drive_m(0, 1, 1, 1, 32'h0000_0100, 32'h1111_0000, 4'hF, 3'd2);
                else                    drive_m(1, 1, 1, 0, 32'h0000_4020, 32'h0, 4'hF, 3'd3);
            end
        end
        clear_all();
        step();
        step();
    endtask

    task automatic test_timeout();
        drive_m(0, 1, 1, 0, 32'h0000_0200, 32'h0, 4'hF, 3'd4);
        step();
        for (int r = 0; r < 2; r++) begin
            for (int c = 1; c <= 4; c++) begin
                if (c < 4) begin
                    checks++; if (master_err !== 2'b00 || slave_stb !== 2'b01) begin errors++; $display("FAIL d_stall_r%0d_c%0d: err %b stb %b want 00/01", r, c, master_err, slave_stb); end
                    step();
                end else begin
                    checks++; if (master_err !== 2'b01) begin errors++; $display("FAIL d_timeout_r%0d: err %b want 01", r, master_err); end
                    checks++; if (slave_stb !== 2'b00 || slave_cyc !== 2'b00) begin errors++; $display("FAIL d_forced_low_r%0d: stb %b cyc %b want 00/00", r, slave_stb, slave_cyc); end
                end
            end
            if (r == 0) step();
        end
        clear_all();
        step();
        checks++; if (master_err !== 2'b00 || grant_valid !== 1'b0) begin errors++; $display("FAIL d_after: err %b valid %0b want 00/0", master_err, grant_valid); end
        drive_m(0, 1, 1, 0, 32'h0000_0300, 32'h0, 4'hF, 3'd4);
        step();
        checks++; if (slave_stb !== 2'b01 || master_err !== 2'b00) begin errors++; $display("FAIL d_next_stb: stb %b err %b want 01/00", slave_stb, master_err); end
        slave_miso = {32'h0, 32'h5A5A_5A5A};
        slave_ack  = 2'b01;
        #1;
        checks++; if (master_ack !== 2'b01 || master_miso !== {2{32'h5A5A_5A5A}}) begin errors++; $display("FAIL d_next_ack: ack %b miso %h want 01/%h", master_ack, master_miso, {2{32'h5A5A_5A5A}}); end
        step();
        clear_all();
        step();
    endtask

    task automatic test_ack_err();
        drive_m(0, 1, 1, 1, 32'h0000_0040, 32'h1234_5678, 4'hF, 3'd5);
        step();
        checks++; if (slave_we !== 2'b11 || slave_sel !== 8'hFF || slave_tag !== {2{3'd5}}) begin errors++; $display("FAIL f_broadcast_ctl: we %b sel %h tag %h want 11/ff/%h", slave_we, slave_sel, slave_tag, {2{3'd5}}); end
        checks++; if (slave_mosi !== {2{32'h1234_5678}}) begin errors++; $display("FAIL f_broadcast_mosi: got %h want %h", slave_mosi, {2{32'h1234_5678}}); end
        slave_ack = 2'b01;
        slave_err = 2'b01;
        #1;
        checks++; if (master_err !== 2'b01 || master_ack !== 2'b00) begin errors++; $display("FAIL f_err_wins: err %b ack %b want 01/00", master_err, master_ack); end
        drive_m(0, 1, 0, 1, 32'h0000_0040, 32'h1234_5678, 4'hF, 3'd5);
        slave_err = 2'b00;
        #1;
        checks++; if (master_ack !== 2'b00 || master_err !== 2'b00) begin errors++; $display("FAIL f_stray_ack: ack %b err %b want 00/00", master_ack, master_err); end
        clear_all();
        step();
        step();
    endtask

    task automatic test_reset_mid();
        drive_m(0, 1, 1, 0, 32'h0000_0080, 32'h0, 4'hF, 3'd6);
        step();
        checks++; if (slave_stb !== 2'b01) begin errors++; $display("FAIL e_pre_stb: got %b want 01", slave_stb); end
        drive_m(1, 1, 1, 0, 32'h0000_4080, 32'h0, 4'hF, 3'd7);
        slave_ack = 2'b01;
        #1;
        sys_rst_n = 1'b0;
        #1;
        checks++; if (slave_cyc !== 2'b00 || slave_stb !== 2'b00) begin errors++; $display("FAIL e_slave_cleared: cyc %b stb %b want 00/00", slave_cyc, slave_stb); end
        checks++; if (master_ack !== 2'b00 || master_err !== 2'b00) begin errors++; $display("FAIL e_master_cleared: ack %b err %b want 00/00", master_ack, master_err); end
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL e_grant_cleared: got %0b want 0", grant_valid); end
        slave_ack = 2'b00;
        step();
        sys_rst_n = 1'b1;
        step();
        checks++; if (grant_valid !== 1'b1 || grant_idx !== 1'b0) begin errors++; $display("FAIL e_first_grant: valid %0b idx %0d want 1/0", grant_valid, grant_idx); end
        clear_all();
        step();
        step();
    endtask

    initial begin
        sys_rst_n = 1'b0;
        clear_all();
        test_reset();
        test_single_read();
        test_decode_miss();
        test_back_to_back();
        test_timeout();
        test_ack_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
